// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Far end of a 4x4 Pmod matrix keypad: answers the decoder's active-low
//   column strobes on active-low row lines while pressing one commanded key.
//   A command runs four phases: press bounce, stable hold, release bounce,
//   released gap. Phase lengths are counted in ticks of TICK_DIV clk cycles.
//
//   Optional feature: define KEYPAD_EMU_BOUNCE_EN to make the contact bounce
//   pseudo-randomly (8-bit LFSR) during both bounce windows. Without it the
//   contact is clean: closed for the whole press window and open for the
//   whole release window. Phase durations are the same in both builds.
module keypad_emulator #(
    parameter int TICK_DIV     = 100,
    parameter int BOUNCE_TICKS = 2000,
    parameter int GAP_TICKS    = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_key,
    input  logic [15:0] cmd_hold,
    input  logic [3:0]  col_n,
    output logic [3:0]  row_n,
    output logic        busy,
    output logic        done
);

    localparam int TW = $clog2(TICK_DIV);

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [15:0]   BOUNCE_LAST = 16'(BOUNCE_TICKS - 1);
    localparam logic [15:0]   GAP_LAST    = 16'(GAP_TICKS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PRESS_B = 3'd1;
    localparam logic [2:0] S_HOLD    = 3'd2;
    localparam logic [2:0] S_REL_B   = 3'd3;
    localparam logic [2:0] S_GAP     = 3'd4;

    logic [2:0]    state;
    logic [TW-1:0] tick_cnt;
    logic          tick;
    logic [15:0]   phase;
    logic [15:0]   hold_last;
    logic          phase_end;
    logic          contact;
    logic [1:0]    row_sel;
    logic [1:0]    col_sel;
    logic          press_bit;
    logic          rel_bit;
    logic [3:0]    key_pos;

    // Contact value on each tick of the bounce windows, and the value it
    // takes on entry to them.
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam logic PRESS_ENTRY = 1'b0;
    localparam logic REL_ENTRY   = 1'b1;

    logic [7:0] lfsr;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, one step per tick in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= 8'hA5;
        end else if (tick) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign press_bit = lfsr[0];
    assign rel_bit   = lfsr[0];
`else
    localparam logic PRESS_ENTRY = 1'b1;
    localparam logic REL_ENTRY   = 1'b0;

    assign press_bit = 1'b1;
    assign rel_bit   = 1'b0;
`endif

    // Free-running tick divider; tick is high for one clk every TICK_DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign tick = (tick_cnt == TICK_LAST);

    // Key code to {row, col} position on the keypad matrix.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through it can leave the value held (no latch).
        key_pos = 4'b0000;
        case (cmd_key)
            4'h1: key_pos = {2'd0, 2'd0};
            4'h2: key_pos = {2'd0, 2'd1};
            4'h3: key_pos = {2'd0, 2'd2};
            4'hA: key_pos = {2'd0, 2'd3};
            4'h4: key_pos = {2'd1, 2'd0};
            4'h5: key_pos = {2'd1, 2'd1};
            4'h6: key_pos = {2'd1, 2'd2};
            4'hB: key_pos = {2'd1, 2'd3};
            4'h7: key_pos = {2'd2, 2'd0};
            4'h8: key_pos = {2'd2, 2'd1};
            4'h9: key_pos = {2'd2, 2'd2};
            4'hC: key_pos = {2'd2, 2'd3};
            4'h0: key_pos = {2'd3, 2'd0};
            4'hF: key_pos = {2'd3, 2'd1};
            4'hE: key_pos = {2'd3, 2'd2};
            4'hD: key_pos = {2'd3, 2'd3};
            default: key_pos = 4'b0000;
        endcase
    end

    // Last phase count of the current state.
    always_comb begin
        phase_end = 1'b0;
        case (state)
            S_PRESS_B, S_REL_B: phase_end = (phase == BOUNCE_LAST);
            S_HOLD:             phase_end = (phase == hold_last);
            S_GAP:              phase_end = (phase == GAP_LAST);
            default:            phase_end = 1'b0;
        endcase
    end

    // Command FSM: phase counter restarts at every state entry and only
    // advances on ticks; contact is forced closed entering HOLD and open
    // entering GAP regardless of the last bounce value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            phase     <= '0;
            hold_last <= '0;
            contact   <= 1'b0;
            done      <= 1'b0;
            row_sel   <= 2'd0;
            col_sel   <= 2'd0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // right-hand side sees the pre-edge value, independent of order.
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    contact <= 1'b0;
                    if (cmd_valid) begin
                        row_sel   <= key_pos[3:2];
                        col_sel   <= key_pos[1:0];
                        // A zero hold is stretched to one tick.
                        hold_last <= (cmd_hold == 16'd0) ? 16'd0 : cmd_hold - 16'd1;
                        phase     <= '0;
                        contact   <= PRESS_ENTRY;
                        state     <= S_PRESS_B;
                    end
                end
                S_PRESS_B: begin
                    if (tick) begin
                        if (phase_end) begin
                            phase   <= '0;
                            contact <= 1'b1;
                            state   <= S_HOLD;
                        end else begin
                            phase   <= phase + 16'd1;
                            contact <= press_bit;
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        if (phase_end) begin
                            phase   <= '0;
                            contact <= REL_ENTRY;
                            state   <= S_REL_B;
                        end else begin
                            phase <= phase + 16'd1;
                        end
                    end
                end
                S_REL_B: begin
                    if (tick) begin
                        if (phase_end) begin
                            phase   <= '0;
                            contact <= 1'b0;
                            state   <= S_GAP;
                        end else begin
                            phase   <= phase + 16'd1;
                            contact <= rel_bit;
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (phase_end) begin
                            phase <= '0;
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            phase <= phase + 16'd1;
                        end
                    end
                end
                default: begin
                    phase   <= '0;
                    contact <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Zero-latency scan response from registered contact/position and live
    // column strobes; any other low column does not mask the pressed one.
    always_comb begin
        row_n = 4'hF;
        if (contact && !col_n[col_sel]) begin
            row_n[row_sel] = 1'b0;
        end
    end

    assign busy      = (state != S_IDLE);
    assign cmd_ready = (state == S_IDLE);

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator
//   Directed bench for keypad_emulator with short tick/phase parameters:
//   a vector table of full key-press commands plus hand-written sequences
//   for reset, back-to-back commands and reset in the middle of HOLD.
module tb_keypad_emulator;

    localparam int TICK_DIV     = 4;
    localparam int BOUNCE_TICKS = 8;
    localparam int GAP_TICKS    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_key;
    logic [15:0] cmd_hold;
    logic [3:0]  col_n;
    logic [3:0]  row_n;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0]  key;
        logic [15:0] hold;
        logic [3:0]  col_n;
        logic [3:0]  exp_row;
    } vec_t;

    vec_t vecs[14];

    keypad_emulator #(
        .TICK_DIV    (TICK_DIV),
        .BOUNCE_TICKS(BOUNCE_TICKS),
        .GAP_TICKS   (GAP_TICKS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_key  (cmd_key),
        .cmd_hold (cmd_hold),
        .col_n    (col_n),
        .row_n    (row_n),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // One full command: accept, watch row_n every cycle, check done timing.
    task automatic run_cmd(input vec_t v, input string tag);
        int   n_ticks;
        int   hold_eff;
        int   win_lo;
        int   win_hi;
        int   done_k;
        int   falls;
        int   rises;
        int   hold_bad;
        logic [3:0] prev;
        hold_eff = (v.hold == 16'd0) ? 1 : int'(v.hold);
        n_ticks  = 2 * BOUNCE_TICKS + hold_eff + GAP_TICKS;
        win_lo   = TICK_DIV * BOUNCE_TICKS;
        win_hi   = TICK_DIV * (BOUNCE_TICKS + hold_eff - 1);
        @(negedge clk);
        col_n    = v.col_n;
        cmd_key  = v.key;
        cmd_hold = v.hold;
        #1;
        check({tag, "_ready_idle"}, int'(cmd_ready), 1);
        check({tag, "_row_idle"}, int'(row_n), 15);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_busy_after_accept"}, int'(busy), 1);
        done_k   = -1;
        falls    = 0;
        rises    = 0;
        hold_bad = 0;
        prev     = 4'hF;
        for (int k = 0; k <= TICK_DIV * (n_ticks + 2); k++) begin
            if (k > 0) @(negedge clk);
            if (row_n != prev) begin
                if (prev == 4'hF) falls++;
                else if (row_n == 4'hF) rises++;
            end
            prev = row_n;
            if (k >= win_lo && k <= win_hi && row_n !== v.exp_row) hold_bad++;
            if (done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        check_range({tag, "_done_cycle"}, done_k, TICK_DIV * n_ticks - TICK_DIV + 1, TICK_DIV * n_ticks);
        check({tag, "_hold_row_errors"}, hold_bad, 0);
`ifdef KEYPAD_EMU_BOUNCE_EN
        if (v.exp_row != 4'hF) check_range({tag, "_press_edges"}, falls, 1, 1000);
        else                   check({tag, "_press_edges"}, falls, 0);
`else
        check({tag, "_falling_edges"}, falls, (v.exp_row != 4'hF) ? 1 : 0);
        check({tag, "_rising_edges"}, rises, (v.exp_row != 4'hF) ? 1 : 0);
`endif
        check({tag, "_row_at_done"}, int'(row_n), 15);
        check({tag, "_ready_at_done"}, int'(cmd_ready), 1);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, int'(done), 0);
        check({tag, "_busy_after_done"}, int'(busy), 0);
    endtask

    initial begin
        int acc;
        int dn;
        int last_done;
        int spacing_bad;
        int busy_bad;
        int ready_bad;
        int done_seen;
        bit chk_busy;

        vecs[0]  = '{4'h5, 16'd10, 4'b1101, 4'b1101};
        vecs[1]  = '{4'h5, 16'd10, 4'b1011, 4'b1111};
        vecs[2]  = '{4'hD, 16'd12, 4'b0111, 4'b0111};
        vecs[3]  = '{4'hD, 16'd12, 4'b1110, 4'b1111};
        vecs[4]  = '{4'h0, 16'd10, 4'b1110, 4'b0111};
        vecs[5]  = '{4'h0, 16'd10, 4'b0111, 4'b1111};
        vecs[6]  = '{4'h1, 16'd16, 4'b1110, 4'b1110};
        vecs[7]  = '{4'hA, 16'd10, 4'b0000, 4'b1110};
        vecs[8]  = '{4'h9, 16'd11, 4'b1011, 4'b1011};
        vecs[9]  = '{4'hF, 16'd10, 4'b1101, 4'b0111};
        vecs[10] = '{4'hE, 16'd10, 4'b1101, 4'b1111};
        vecs[11] = '{4'hC, 16'd14, 4'b0111, 4'b1011};
        vecs[12] = '{4'h6, 16'd10, 4'b1011, 4'b1101};
        vecs[13] = '{4'h7, 16'd10, 4'b1111, 4'b1111};

        // Reset with every column strobed and a command offered.
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_key   = 4'h5;
        cmd_hold  = 16'd10;
        col_n     = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_row", int'(row_n), 15);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        cmd_valid = 1'b0;
        rst       = 1'b0;
        repeat (2) @(negedge clk);
        check("post_rst_row", int'(row_n), 15);
        check("post_rst_busy", int'(busy), 0);

        // Table of full commands.
        for (int i = 0; i < 14; i++) begin
            run_cmd(vecs[i], $sformatf("v%0d", i));
        end

        // Back-to-back: cmd_valid held high, hold 0 behaves as 1 tick.
        @(negedge clk);
        cmd_key     = 4'h1;
        cmd_hold    = 16'd0;
        col_n       = 4'b1110;
        cmd_valid   = 1'b1;
        acc         = 0;
        dn          = 0;
        last_done   = -1;
        spacing_bad = 0;
        busy_bad    = 0;
        ready_bad   = 0;
        chk_busy    = 1'b0;
        for (int c = 0; c < 1000 && dn < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (chk_busy && busy !== 1'b1) busy_bad++;
            chk_busy = 1'b0;
            if (cmd_ready === 1'b1) acc++;
            if (done === 1'b1) begin
                if (cmd_ready !== 1'b1) ready_bad++;
                if (last_done >= 0 &&
                    ((c - last_done) < TICK_DIV * (2 * BOUNCE_TICKS + 1 + GAP_TICKS) - 2 ||
                     (c - last_done) > TICK_DIV * (2 * BOUNCE_TICKS + 1 + GAP_TICKS) + 1))
                    spacing_bad++;
                last_done = c;
                dn++;
                chk_busy = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        check("b2b_done_count", dn, 3);
        check("b2b_accept_offers", acc, 4);
        check("b2b_spacing_errors", spacing_bad, 0);
        check("b2b_restart_busy_errors", busy_bad, 0);
        check("b2b_ready_at_done_errors", ready_bad, 0);
        @(negedge clk);
        check("b2b_idle_after", int'(busy), 0);

        // Reset in the middle of HOLD: row released without a clock edge.
        @(negedge clk);
        cmd_key   = 4'h5;
        cmd_hold  = 16'd10;
        col_n     = 4'b1101;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (50) @(negedge clk);
        check("midrst_row_before", int'(row_n), 13);
        #2 rst = 1'b1;
        #1;
        check("midrst_row_async", int'(row_n), 15);
        @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        check("midrst_no_done", done_seen, 0);
        check("midrst_idle", int'(busy), 0);
        run_cmd(vecs[0], "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
